if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL provide parameter RESET_VECTOR, default 32'h0000_0000, fetch address after reset.
REQ-002 SHALL provide parameter NOP_INSN, default 32'h0000_0013, instruction placed in if_insn when the slot is a bubble.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 stall  in  1  hold IF/ID register and PC.
REQ-006 flush  in  1  squash IF/ID and redirect to new_pc.
REQ-007 new_pc  in  32  flush target address.
REQ-008 br_taken  in  1  branch resolved taken in ID.
REQ-009 br_addr  in  32  branch target.
REQ-010 imem_req  out  1  instruction fetch request.
REQ-011 imem_addr  out  32  fetch address, word aligned.
REQ-012 imem_rdy  in  1  fetch response valid this cycle.
REQ-013 imem_rd_data  in  32  fetched instruction.
REQ-014 busy  out  1  fetch outstanding and no response this cycle.
REQ-015 if_en  out  1  IF/ID slot holds a valid instruction.
REQ-016 if_pc  out  32  PC of instruction in IF/ID.
REQ-017 if_insn  out  32  instruction in IF/ID.

Function
REQ-018 FSM states SHALL be IDLE, REQ (request pending) and DISCARD (request pending, response to be dropped).
REQ-019 IDLE SHALL drive imem_req=0 and move to REQ on the next cycle.
REQ-020 In REQ and DISCARD, imem_req SHALL be 1 and imem_addr SHALL be the current fetch PC, held stable until imem_rdy=1.
REQ-021 busy SHALL equal imem_req & ~imem_rdy.
REQ-022 Event priority SHALL be reset > flush > stall > br_taken > normal fetch.
REQ-023 Normal fetch: in REQ with imem_rdy=1, the next edge SHALL set if_en=1, if_pc=PC, if_insn=imem_rd_data and PC=PC+4 (mod 2^32; wraps from 32'hFFFF_FFFC to 0). The FSM SHALL stay in REQ, giving one instruction per cycle when imem_rdy is held high.
REQ-024 In REQ with imem_rdy=0 and no stall: the next edge SHALL set if_en=0, if_insn=NOP_INSN and leave if_pc unchanged.
REQ-025 stall=1: if_en, if_pc, if_insn and PC SHALL hold. A response arriving in that cycle is handled per REQ-034.
REQ-026 flush=1 or br_taken=1 with imem_rdy=1: the next edge SHALL set PC to the target (new_pc or br_addr, with bits[1:0] forced to 00), if_en=0 and if_insn=NOP_INSN; the response is dropped and the FSM stays in REQ.
REQ-027 flush=1 or br_taken=1 with imem_rdy=0: the target SHALL be latched into a pending register, the FSM SHALL enter DISCARD, and if_en SHALL become 0. imem_addr SHALL remain the old PC.
REQ-028 DISCARD with imem_rdy=1: the response SHALL be dropped, PC SHALL load the pending target, and the FSM SHALL return to REQ.
REQ-029 A further flush or br_taken in DISCARD SHALL overwrite the pending target; flush SHALL win if both are asserted.
REQ-030 br_taken during stall SHALL be ignored; ID re-asserts it after the stall ends.

Reset
REQ-031 While reset=0 at a clk edge, the block SHALL set: FSM=IDLE, PC=RESET_VECTOR, if_en=0, if_pc=RESET_VECTOR, if_insn=NOP_INSN, pending target=0, instruction buffer empty.
REQ-032 Reset asserted while a request is outstanding SHALL abandon that request; the first post-reset request is to RESET_VECTOR.
REQ-033 Outputs SHALL be stable between edges; there is no asynchronous path from reset.

Configuration
REQ-034 IF_INSN_BUF_EN, with the macro defined:
- A response with imem_rdy=1 arriving during stall in REQ SHALL be captured into a one-entry buffer, and PC SHALL advance by 4.
- When the buffer is full, imem_req SHALL be 0.
- On the first non-stall cycle, the buffer contents SHALL load IF/ID, the buffer SHALL empty and fetching SHALL resume.
- flush or br_taken SHALL empty the buffer.
Without the macro, such a response SHALL be dropped and the same PC refetched after the stall.

Verification
REQ-035 Reset release, imem_rdy=1 held -> imem_addr 0,4,8; if_pc 0,4,8 on consecutive cycles; if_en=1 from the second post-reset edge onward.
REQ-036 imem_rdy low 3 cycles at addr 8 -> busy=1 for 3 cycles, if_en=0 bubbles, imem_addr stays 8, then if_pc=8.
REQ-037 br_taken with br_addr=32'h100 while imem_rdy=0 -> DISCARD; the old response is dropped; next imem_addr=32'h100; the following valid slot has if_pc=32'h100.
REQ-038 flush with new_pc=32'h200 and br_taken with br_addr=32'h300 in the same cycle -> next fetch is 32'h200.
REQ-039 stall for 2 cycles while imem_rdy=1 at addr 32'h10 -> IF/ID holds. With IF_INSN_BUF_EN: if_pc=32'h10 on the first cycle after the stall and imem_req=0 during the stall. Without the macro: addr 32'h10 is refetched.
REQ-040 reset=0 mid-wait at PC=32'h40 -> if_en=0, one IDLE cycle, then imem_addr=RESET_VECTOR.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing, imem handshake, branch/flush redirect and IF/ID register.
// Optional one-entry stall buffer enabled by defining IF_INSN_BUF_EN.
module if_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN     = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        br_taken,
    input  logic [31:0] br_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_rd_data,
    output logic        busy,
    output logic        if_en,
    output logic [31:0] if_pc,
    output logic [31:0] if_insn
);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] pend_pc, pend_nxt;
    logic        if_en_nxt;
    logic [31:0] if_pc_nxt, if_insn_nxt;
    logic        redirect;
    logic [31:0] target;
    logic        resp;
    logic        buf_full;

`ifdef IF_INSN_BUF_EN
    logic        buf_valid, buf_valid_nxt;
    logic [31:0] buf_pc, buf_pc_nxt;
    logic [31:0] buf_insn, buf_insn_nxt;
    assign buf_full = buf_valid;
`else
    assign buf_full = 1'b0;
`endif

    assign imem_req  = (state != IDLE) && !buf_full;
    assign imem_addr = pc;
    assign busy      = imem_req & ~imem_rdy;
    assign resp      = imem_req & imem_rdy;

    // flush beats stall; a branch seen during stall is dropped and re-asserted later by ID
    always_comb begin
        redirect = 1'b0;
        target   = '0;
        if (flush) begin
            redirect = 1'b1;
            target   = {new_pc[31:2], 2'b00};
        end else if (br_taken && !stall) begin
            redirect = 1'b1;
            target   = {br_addr[31:2], 2'b00};
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        pend_nxt    = pend_pc;
        if_en_nxt   = if_en;
        if_pc_nxt   = if_pc;
        if_insn_nxt = if_insn;
`ifdef IF_INSN_BUF_EN
        buf_valid_nxt = buf_valid;
        buf_pc_nxt    = buf_pc;
        buf_insn_nxt  = buf_insn;
`endif
        case (state)
            IDLE: begin
                state_nxt = REQ;
                if (redirect) begin
                    pc_nxt      = target;
                    if_en_nxt   = 1'b0;
                    if_insn_nxt = NOP_INSN;
                end
            end
            REQ: begin
                if (redirect) begin
                    if_en_nxt   = 1'b0;
                    if_insn_nxt = NOP_INSN;
`ifdef IF_INSN_BUF_EN
                    buf_valid_nxt = 1'b0;
`endif
                    // With no request outstanding (buffer full) there is nothing to discard
                    if (resp || !imem_req) begin
                        pc_nxt = target;
                    end else begin
                        pend_nxt  = target;
                        state_nxt = DISCARD;
                    end
                end else if (stall) begin
`ifdef IF_INSN_BUF_EN
                    if (resp) begin
                        buf_valid_nxt = 1'b1;
                        buf_pc_nxt    = pc;
                        buf_insn_nxt  = imem_rd_data;
                        pc_nxt        = pc + 32'd4;
                    end
`endif
                end else begin
`ifdef IF_INSN_BUF_EN
                    if (buf_valid) begin
                        if_en_nxt     = 1'b1;
                        if_pc_nxt     = buf_pc;
                        if_insn_nxt   = buf_insn;
                        buf_valid_nxt = 1'b0;
                    end else
`endif
                    if (resp) begin
                        if_en_nxt   = 1'b1;
                        if_pc_nxt   = pc;
                        if_insn_nxt = imem_rd_data;
                        pc_nxt      = pc + 32'd4;
                    end else begin
                        if_en_nxt   = 1'b0;
                        if_insn_nxt = NOP_INSN;
                    end
                end
            end
            DISCARD: begin
                if_en_nxt   = 1'b0;
                if_insn_nxt = NOP_INSN;
                if (redirect) begin
                    pend_nxt = target;
                end
                if (imem_rdy) begin
                    pc_nxt    = redirect ? target : pend_pc;
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            pc      <= RESET_VECTOR;
            pend_pc <= '0;
            if_en   <= 1'b0;
            if_pc   <= RESET_VECTOR;
            if_insn <= NOP_INSN;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            pend_pc <= pend_nxt;
            if_en   <= if_en_nxt;
            if_pc   <= if_pc_nxt;
            if_insn <= if_insn_nxt;
        end
    end

`ifdef IF_INSN_BUF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            buf_valid <= 1'b0;
            buf_pc    <= '0;
            buf_insn  <= '0;
        end else begin
            buf_valid <= buf_valid_nxt;
            buf_pc    <= buf_pc_nxt;
            buf_insn  <= buf_insn_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; the instruction memory answers addr ^ 32'h1234_0000.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        br_taken;
    logic [31:0] br_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy;
    logic [31:0] imem_rd_data;
    logic        busy;
    logic        if_en;
    logic [31:0] if_pc;
    logic [31:0] if_insn;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    if_stage #(
        .RESET_VECTOR(32'h0000_0000),
        .NOP_INSN    (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .new_pc      (new_pc),
        .br_taken    (br_taken),
        .br_addr     (br_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdy    (imem_rdy),
        .imem_rd_data(imem_rd_data),
        .busy        (busy),
        .if_en       (if_en),
        .if_pc       (if_pc),
        .if_insn     (if_insn)
    );

    assign imem_rd_data = imem_addr ^ 32'h1234_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0; new_pc = '0;
        br_taken = 1'b0; br_addr = '0; imem_rdy = 1'b0;
        tick(); tick();
        check("rst_if_en", if_en, 0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_insn", if_insn, NOP);
        check("rst_req", imem_req, 0);

        // Reset release, streaming fetch
        reset = 1'b1; imem_rdy = 1'b1;
        tick();
        check("rel_req", imem_req, 1);
        check("rel_addr", imem_addr, 32'h0);
        check("rel_if_en", if_en, 0);
        tick();
        check("f0_if_en", if_en, 1);
        check("f0_if_pc", if_pc, 32'h0);
        check("f0_insn", if_insn, 32'h1234_0000);
        check("f0_addr", imem_addr, 32'h4);
        tick();
        check("f1_if_pc", if_pc, 32'h4);
        check("f1_addr", imem_addr, 32'h8);

        // Three wait cycles at address 8
        imem_rdy = 1'b0; #1;
        check("w1_busy", busy, 1);
        tick();
        check("w1_if_en", if_en, 0);
        check("w1_insn", if_insn, NOP);
        check("w1_if_pc", if_pc, 32'h4);
        check("w2_busy", busy, 1);
        tick();
        check("w2_addr", imem_addr, 32'h8);
        check("w3_busy", busy, 1);
        tick();
        check("w3_if_en", if_en, 0);
        imem_rdy = 1'b1; #1;
        check("w_done_busy", busy, 0);
        tick();
        check("w_if_pc", if_pc, 32'h8);
        check("w_if_en", if_en, 1);
        check("w_insn", if_insn, 32'h1234_0008);
        check("w_addr", imem_addr, 32'hC);

        // Branch while waiting -> DISCARD
        imem_rdy = 1'b0; br_taken = 1'b1; br_addr = 32'h100;
        tick();
        check("br_if_en", if_en, 0);
        check("br_old_addr", imem_addr, 32'hC);
        check("br_req", imem_req, 1);
        br_taken = 1'b0; imem_rdy = 1'b1;
        tick();
        check("br_new_addr", imem_addr, 32'h100);
        check("br_drop_if_en", if_en, 0);
        tick();
        check("br_if_pc", if_pc, 32'h100);
        check("br_insn", if_insn, 32'h1234_0100);
        check("br_if_en2", if_en, 1);

        // Flush beats branch, target low bits cleared
        flush = 1'b1; new_pc = 32'h203; br_taken = 1'b1; br_addr = 32'h300;
        tick();
        check("fl_addr", imem_addr, 32'h200);
        check("fl_if_en", if_en, 0);
        check("fl_insn", if_insn, NOP);
        flush = 1'b0; br_taken = 1'b0;
        tick();
        check("fl_if_pc", if_pc, 32'h200);
        check("fl_next_addr", imem_addr, 32'h204);

        // Pending target overwritten in DISCARD
        imem_rdy = 1'b0; br_taken = 1'b1; br_addr = 32'h300;
        tick();
        check("ov_addr0", imem_addr, 32'h204);
        br_taken = 1'b0; flush = 1'b1; new_pc = 32'h500;
        tick();
        check("ov_addr1", imem_addr, 32'h204);
        flush = 1'b0; imem_rdy = 1'b1;
        tick();
        check("ov_addr2", imem_addr, 32'h500);
        tick();
        check("ov_if_pc", if_pc, 32'h500);

        // Branch during stall is ignored
        imem_rdy = 1'b0; stall = 1'b1; br_taken = 1'b1; br_addr = 32'h700;
        tick();
        check("sb_addr", imem_addr, 32'h504);
        check("sb_if_pc", if_pc, 32'h500);
        check("sb_if_en", if_en, 1);
        stall = 1'b0; br_taken = 1'b0; imem_rdy = 1'b1;
        tick();
        check("sb_after_pc", if_pc, 32'h504);
        check("sb_after_addr", imem_addr, 32'h508);

        // Stall with a response at address 0x10
        flush = 1'b1; new_pc = 32'hC;
        tick();
        flush = 1'b0;
        tick();
        check("st_pre_pc", if_pc, 32'hC);
        check("st_pre_addr", imem_addr, 32'h10);
        stall = 1'b1; #1;
        check("st_req0", imem_req, 1);
        tick();
        check("st1_if_pc", if_pc, 32'hC);
        check("st1_if_en", if_en, 1);
`ifdef IF_INSN_BUF_EN
        check("st1_req", imem_req, 0);
`else
        check("st1_req", imem_req, 1);
        check("st1_addr", imem_addr, 32'h10);
`endif
        tick();
        check("st2_if_pc", if_pc, 32'hC);
`ifdef IF_INSN_BUF_EN
        check("st2_req", imem_req, 0);
`else
        check("st2_addr", imem_addr, 32'h10);
`endif
        stall = 1'b0;
        tick();
        check("st_out_pc", if_pc, 32'h10);
        check("st_out_insn", if_insn, 32'h1234_0010);
        check("st_out_en", if_en, 1);
        check("st_out_addr", imem_addr, 32'h14);
        check("st_out_req", imem_req, 1);

        // PC wraps past the top of the address space
        flush = 1'b1; new_pc = 32'hFFFF_FFFC;
        tick();
        check("wr_addr", imem_addr, 32'hFFFF_FFFC);
        flush = 1'b0;
        tick();
        check("wr_if_pc", if_pc, 32'hFFFF_FFFC);
        check("wr_insn", if_insn, 32'hEDCB_FFFC);
        check("wr_next", imem_addr, 32'h0);

        // Reset while a request to 0x40 is outstanding
        flush = 1'b1; new_pc = 32'h40;
        tick();
        flush = 1'b0; imem_rdy = 1'b0;
        tick();
        check("mr_addr", imem_addr, 32'h40);
        check("mr_busy", busy, 1);
        reset = 1'b0;
        tick();
        check("mr_if_en", if_en, 0);
        check("mr_req", imem_req, 0);
        check("mr_if_pc", if_pc, 32'h0);
        check("mr_insn", if_insn, NOP);
        check("mr_busy0", busy, 0);
        reset = 1'b1;
        tick();
        check("mr_req1", imem_req, 1);
        check("mr_addr1", imem_addr, 32'h0);
        imem_rdy = 1'b1;
        tick();
        check("mr_if_pc1", if_pc, 32'h0);
        check("mr_if_en1", if_en, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
